cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the CPU core.
- Sequences the program counter (drives its `we`/`jump` inputs), the instruction register, the register-file write and the data-memory handshake, one instruction at a time.
- Sits between the decoded opcode field of the IR and the datapath enables.
- Also reports halt/error status and a retired-instruction count.

---
 rtl/cpu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the CPU core.
//
// Steps one instruction at a time through FETCH, DECODE, EXEC, optional MEM
// and WB. It drives the program-counter enables, the IR load, the register-file
// write and the instruction/data memory requests. It also reports halt/error
// status and counts retired instructions.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               1 = a new instruction fetch may be started
//   op                opcode field of the current IR; class = op[OP_WIDTH-1 -: 3]
//   cond              branch condition, sampled in EXEC
//   imem_ack/dmem_ack memory acknowledges
//   pc_we, pc_jump    PC write enable / select (0 = pc+1, 1 = branch target)
//   ir_we, rf_we      IR load / register-file write
//   imem_req          instruction fetch request
//   dmem_req, dmem_we data request and write qualifier
//   halted, error     terminal status
//   retired           count of completed instructions (wraps)
//   state_dbg         current FSM state, for debug and checkers
//
// Handshake: a request (imem_req or dmem_req) stays high once raised until the
// cycle in which its ack is high, and that cycle completes the transfer. An ack
// seen while the matching request is low is ignored. If a request sees TIMEOUT
// cycles with no ack, the FSM goes to ERROR and the request drops. An ack on the
// TIMEOUT-th cycle still completes the transfer.
module cpu_sequencer #(
  parameter int OP_WIDTH = 6,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                cond,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                pc_we,
  output logic                pc_jump,
  output logic                ir_we,
  output logic                rf_we,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                halted,
  output logic                error,
  output logic [31:0]         retired,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [2:0] C_ALU    = 3'b000;
  localparam logic [2:0] C_LOAD   = 3'b001;
  localparam logic [2:0] C_STORE  = 3'b010;
  localparam logic [2:0] C_JUMP   = 3'b011;
  localparam logic [2:0] C_BRANCH = 3'b100;
  localparam logic [2:0] C_ILL    = 3'b110;
  localparam logic [2:0] C_HALT   = 3'b111;

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [2:0]    class_q;
  logic          cond_q;
  logic [CW-1:0] to_cnt;
  logic          fetch_pend;
  logic [31:0]   retired_q;
  logic [2:0]    op_class;
  logic          op_unused;

  logic pc_we_c, pc_jump_c, ir_we_c, rf_we_c, imem_req_c, dmem_req_c, dmem_we_c;
  logic req_wait;

  assign op_class  = op[OP_WIDTH-1 -: 3];
  assign op_unused = ^op[OP_WIDTH-4:0];

  always_comb begin
    state_nx   = state;
    pc_we_c    = 1'b0;
    pc_jump_c  = 1'b0;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    req_wait   = 1'b0;
    case (state)
      // The PC resets to all-ones; one increment here brings it to 0.
      S_INIT: begin
        pc_we_c  = 1'b1;
        state_nx = S_FETCH;
      end
      // Once raised, the fetch request is kept even if run drops.
      S_FETCH: begin
        imem_req_c = run | fetch_pend;
        if (imem_req_c && imem_ack) begin
          ir_we_c  = 1'b1;
          state_nx = S_DECODE;
        end else if (imem_req_c) begin
          req_wait = 1'b1;
          if (to_cnt == TO_LAST) state_nx = S_ERROR;
        end
      end
      S_DECODE: begin
        case (op_class)
          C_ILL:   state_nx = S_ERROR;
          C_HALT:  state_nx = S_HALT;
          default: state_nx = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (class_q == C_LOAD || class_q == C_STORE) state_nx = S_MEM;
        else                                         state_nx = S_WB;
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (class_q == C_STORE);
        if (dmem_ack) begin
          state_nx = S_WB;
        end else begin
          req_wait = 1'b1;
          if (to_cnt == TO_LAST) state_nx = S_ERROR;
        end
      end
      S_WB: begin
        pc_we_c   = 1'b1;
        rf_we_c   = (class_q == C_ALU) || (class_q == C_LOAD);
        pc_jump_c = (class_q == C_JUMP) || (class_q == C_BRANCH && cond_q);
        state_nx  = S_FETCH;
      end
      default: state_nx = state;  // HALT and ERROR are absorbing
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      class_q    <= 3'b000;
      cond_q     <= 1'b0;
      to_cnt     <= '0;
      fetch_pend <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      state      <= state_nx;
      fetch_pend <= (state_nx == S_FETCH) && imem_req_c && !imem_ack;
      if (state == S_DECODE) class_q <= op_class;
      if (state == S_EXEC)   cond_q  <= cond;
      if (state == S_WB)     retired_q <= retired_q + 32'd1;
      // Cleared in every state that precedes an entry to FETCH or MEM.
      if (req_wait)
        to_cnt <= to_cnt + 1'b1;
      else if (state != S_FETCH && state != S_MEM)
        to_cnt <= '0;
    end
  end

  // State resets to INIT, whose pc_we pulse must stay hidden while rst is high.
  assign pc_we     = pc_we_c    & ~rst;
  assign pc_jump   = pc_jump_c  & ~rst;
  assign ir_we     = ir_we_c    & ~rst;
  assign rf_we     = rf_we_c    & ~rst;
  assign imem_req  = imem_req_c & ~rst;
  assign dmem_req  = dmem_req_c & ~rst;
  assign dmem_we   = dmem_we_c  & ~rst;
  assign halted    = (state == S_HALT)  & ~rst;
  assign error     = (state == S_ERROR) & ~rst;
  assign retired   = retired_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Each scenario task drives stimulus,
// pushes expected write-back records {rf_we, pc_jump, retired} to exp_q, and
// pops and compares them when the DUT shows its write-back cycle.
module tb_cpu_sequencer;
  localparam int OP_WIDTH = 6;
  localparam int TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst, run, cond, imem_ack, dmem_ack;
  logic [5:0]  op;
  logic        pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we;
  logic        halted, error;
  logic [31:0] retired;
  logic [2:0]  state_dbg;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  cpu_sequencer #(.OP_WIDTH(OP_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .cond(cond),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_jump(pc_jump), .ir_we(ir_we), .rf_we(rf_we),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .halted(halted), .error(error), .retired(retired), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];
  logic [31:0] exp_ret;

  typedef struct packed {
    int          cycles;
    int          ir_at;
    int          wb_at;
    int          ir_n;
    int          dreq_n;
    int          dwe_n;
    bit          wb_seen;
    bit          stray;
    bit          err;
    bit          halt;
    logic [33:0] wb;
    logic [6:0]  ends;
  } obs_t;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; cond = 1'b0; op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ret = 32'd0;
    exp_q.delete();
  endtask

  // Runs one instruction with reactive acks until write-back, HALT or ERROR.
  // dmem_ack is given after dly cycles of dmem_req. cond carries cond_v only
  // in the EXEC cycle, so a sequencer that fails to latch it will misbehave.
  task automatic drive_instr(input logic [5:0] op_v, input logic cond_v,
                             input int dly, output obs_t o);
    int dcnt;
    o = '0;
    o.ir_at = -1;
    o.wb_at = -1;
    dcnt = 0;
    while (!o.wb_seen && !o.err && !o.halt && o.cycles < 200) begin
      @(negedge clk);
      run = 1'b1; op = op_v; imem_ack = 1'b0; dmem_ack = 1'b0;
      cond = (o.ir_n > 0 && o.cycles == o.ir_at + 2) ? cond_v : ~cond_v;
      #1;
      imem_ack = imem_req;
      dmem_ack = dmem_req && (dcnt == dly);
      #1;
      if (ir_we) begin o.ir_n = o.ir_n + 1; o.ir_at = o.cycles; end
      if (dmem_req) begin o.dreq_n = o.dreq_n + 1; dcnt = dcnt + 1; end
      if (dmem_we) o.dwe_n = o.dwe_n + 1;
      if ((rf_we || pc_jump) && !pc_we) o.stray = 1'b1;
      if (dmem_we && !dmem_req) o.stray = 1'b1;
      if (pc_we) begin o.wb_seen = 1'b1; o.wb_at = o.cycles; o.wb = {rf_we, pc_jump, retired}; end
      if (error || halted) begin
        o.err  = error;
        o.halt = halted;
        o.ends = {pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we};
      end
      o.cycles = o.cycles + 1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; op = '0; cond = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    n_checks++;
    if ({pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we, halted, error} !== 9'd0
        || retired !== 32'd0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got outs=%b retired=%0d state=%0d, expected all 0",
               {pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we, halted, error},
               retired, state_dbg);
    end
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0; rst = 1'b0;
    exp_ret = 32'd0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL init_pulse: got %b, expected 1000000",
               {pc_we, pc_jump, ir_we, rf_we, imem_req, dmem_req, dmem_we});
    end
  endtask

  task automatic test_alu_jump();
    obs_t o;
    logic [33:0] e;
    exp_q.push_back({1'b1, 1'b0, exp_ret});
    drive_instr(6'b000101, 1'b0, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.wb !== e) begin
      n_fail++;
      $display("FAIL alu_wb: got %h (seen=%0d), expected %h", o.wb, o.wb_seen, e);
    end
    n_checks++;
    if (o.cycles != 4 || o.ir_at != 0 || o.wb_at != 3 || o.ir_n != 1 || o.stray) begin
      n_fail++;
      $display("FAIL alu_timing: got cycles=%0d ir_at=%0d wb_at=%0d ir_n=%0d stray=%0d, expected 4 0 3 1 0",
               o.cycles, o.ir_at, o.wb_at, o.ir_n, o.stray);
    end
    @(posedge clk); #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL alu_retired: got %0d, expected %0d", retired, exp_ret);
    end
    exp_q.push_back({1'b0, 1'b1, exp_ret});
    drive_instr(6'b011010, 1'b0, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.wb !== e || o.cycles != 4) begin
      n_fail++;
      $display("FAIL jump_wb: got %h cycles=%0d, expected %h cycles=4", o.wb, o.cycles, e);
    end
  endtask

  task automatic test_load_store();
    obs_t o;
    logic [33:0] e;
    apply_reset();
    exp_q.push_back({1'b1, 1'b0, exp_ret});
    drive_instr(6'b001011, 1'b1, 3, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.wb !== e) begin
      n_fail++;
      $display("FAIL load_wb: got %h, expected %h", o.wb, e);
    end
    n_checks++;
    if (o.cycles != 8 || o.dreq_n != 4 || o.dwe_n != 0 || o.stray) begin
      n_fail++;
      $display("FAIL load_mem: got cycles=%0d dreq=%0d dwe=%0d stray=%0d, expected 8 4 0 0",
               o.cycles, o.dreq_n, o.dwe_n, o.stray);
    end
    exp_q.push_back({1'b1, 1'b0, exp_ret});
    drive_instr(6'b001000, 1'b0, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.wb !== e || o.cycles != 5) begin
      n_fail++;
      $display("FAIL load_fast: got %h cycles=%0d, expected %h cycles=5", o.wb, o.cycles, e);
    end
    // Ack arrives on the last allowed cycle: the transfer must still complete.
    exp_q.push_back({1'b0, 1'b0, exp_ret});
    drive_instr(6'b010111, 1'b1, TIMEOUT - 1, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.err || o.wb !== e) begin
      n_fail++;
      $display("FAIL store_ack_at_limit: got %h err=%0d, expected %h err=0", o.wb, o.err, e);
    end
    n_checks++;
    if (o.dreq_n != TIMEOUT || o.dwe_n != TIMEOUT || o.cycles != 4 + TIMEOUT) begin
      n_fail++;
      $display("FAIL store_limit_len: got dreq=%0d dwe=%0d cycles=%0d, expected %0d %0d %0d",
               o.dreq_n, o.dwe_n, o.cycles, TIMEOUT, TIMEOUT, 4 + TIMEOUT);
    end
  endtask

  task automatic test_branch();
    obs_t o;
    logic [33:0] e;
    int rf_seen;
    apply_reset();
    rf_seen = 0;
    exp_q.push_back({1'b0, 1'b1, exp_ret});
    drive_instr(6'b100001, 1'b1, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    if (o.wb[33] || o.stray) rf_seen++;
    n_checks++;
    if (!o.wb_seen || o.wb !== e) begin
      n_fail++;
      $display("FAIL branch_taken: got %h, expected %h", o.wb, e);
    end
    exp_q.push_back({1'b0, 1'b0, exp_ret});
    drive_instr(6'b100110, 1'b0, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    if (o.wb[33] || o.stray) rf_seen++;
    n_checks++;
    if (!o.wb_seen || o.wb !== e) begin
      n_fail++;
      $display("FAIL branch_not_taken: got %h, expected %h", o.wb, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (retired !== exp_ret || rf_seen != 0) begin
      n_fail++;
      $display("FAIL branch_retired: got retired=%0d rf_events=%0d, expected %0d 0",
               retired, rf_seen, exp_ret);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [33:0] e;
    apply_reset();
    exp_q.push_back({1'b1, 1'b0, exp_ret});
    drive_instr(6'b000000, 1'b0, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (o.wb !== e) begin
      n_fail++;
      $display("FAIL pre_timeout_alu: got %h, expected %h", o.wb, e);
    end
    drive_instr(6'b010000, 1'b0, 100000, o);
    n_checks++;
    if (!o.err || o.wb_seen || o.dreq_n != TIMEOUT || o.dwe_n != TIMEOUT || o.ends !== 7'd0) begin
      n_fail++;
      $display("FAIL store_timeout: got err=%0d wb=%0d dreq=%0d dwe=%0d ends=%b, expected 1 0 %0d %0d 0",
               o.err, o.wb_seen, o.dreq_n, o.dwe_n, o.ends, TIMEOUT, TIMEOUT);
    end
    @(negedge clk);
    run = 1'b1; dmem_ack = 1'b1; imem_ack = 1'b1;
    #1;
    n_checks++;
    if (!error || dmem_req || imem_req || ir_we || pc_we) begin
      n_fail++;
      $display("FAIL error_absorbing: got error=%0d dreq=%0d ireq=%0d ir_we=%0d pc_we=%0d, expected 1 0 0 0 0",
               error, dmem_req, imem_req, ir_we, pc_we);
    end
    apply_reset();
    #1;
    n_checks++;
    if (error || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL error_cleared: got error=%0d retired=%0d, expected 0 0", error, retired);
    end
  endtask

  task automatic test_run_gate();
    obs_t o;
    logic [33:0] e;
    int req_n, ir_n;
    apply_reset();
    req_n = 0; ir_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run = 1'b0; imem_ack = (i == 2);
      #1;
      if (imem_req) req_n++;
      if (ir_we) ir_n++;
    end
    n_checks++;
    if (req_n != 0 || ir_n != 0) begin
      n_fail++;
      $display("FAIL run_low_idle: got req_cycles=%0d ir_we=%0d, expected 0 0", req_n, ir_n);
    end
    @(negedge clk);
    run = 1'b1; imem_ack = 1'b0;
    #1;
    req_n = imem_req ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      if (imem_req) req_n++;
      if (ir_we) ir_n++;
    end
    n_checks++;
    if (req_n != 4 || ir_n != 0) begin
      n_fail++;
      $display("FAIL req_held: got req_cycles=%0d ir_we=%0d, expected 4 0", req_n, ir_n);
    end
    @(negedge clk);
    run = 1'b0; imem_ack = 1'b1;
    #1;
    n_checks++;
    if (!ir_we || !imem_req) begin
      n_fail++;
      $display("FAIL held_req_ack: got ir_we=%0d req=%0d, expected 1 1", ir_we, imem_req);
    end
    exp_q.push_back({1'b0, 1'b0, exp_ret});
    drive_instr(6'b101000, 1'b1, 0, o);
    exp_ret++;
    e = exp_q.pop_front();
    n_checks++;
    if (!o.wb_seen || o.wb !== e || o.cycles != 3) begin
      n_fail++;
      $display("FAIL nop_after_stall: got %h cycles=%0d, expected %h cycles=3", o.wb, o.cycles, e);
    end
  endtask

  task automatic test_halt_error();
    obs_t o;
    int bad;
    apply_reset();
    drive_instr(6'b111000, 1'b0, 0, o);
    n_checks++;
    if (!o.halt || o.err || o.wb_seen || o.ends !== 7'd0 || o.cycles != 3) begin
      n_fail++;
      $display("FAIL halt_entry: got halt=%0d err=%0d wb=%0d ends=%b cycles=%0d, expected 1 0 0 0 3",
               o.halt, o.err, o.wb_seen, o.ends, o.cycles);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; imem_ack = 1'b1;
      #1;
      if (ir_we || imem_req || pc_we || !halted) bad++;
    end
    imem_ack = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_stray_ack: got %0d bad cycles, expected 0", bad);
    end
    apply_reset();
    drive_instr(6'b110000, 1'b0, 0, o);
    n_checks++;
    if (!o.err || o.halt || o.wb_seen || o.ends !== 7'd0) begin
      n_fail++;
      $display("FAIL illegal_op: got err=%0d halt=%0d wb=%0d ends=%b, expected 1 0 0 0",
               o.err, o.halt, o.wb_seen, o.ends);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [33:0] e;
    logic [2:0]  cls;
    logic        c;
    int          dly, exp_cyc;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      cls = 3'($urandom_range(5, 0));
      c   = 1'($urandom_range(1, 0));
      dly = $urandom_range(4, 0);
      exp_q.push_back({(cls == 3'b000 || cls == 3'b001),
                       (cls == 3'b011 || (cls == 3'b100 && c)), exp_ret});
      exp_cyc = (cls == 3'b001 || cls == 3'b010) ? 5 + dly : 4;
      drive_instr({cls, 3'($urandom_range(7, 0))}, c, dly, o);
      exp_ret++;
      e = exp_q.pop_front();
      n_checks++;
      if (!o.wb_seen || o.wb !== e || o.cycles != exp_cyc || o.stray) begin
        n_fail++;
        $display("FAIL b2b[%0d] cls=%0d: got %h cycles=%0d stray=%0d, expected %h cycles=%0d",
                 i, cls, o.wb, o.cycles, o.stray, e, exp_cyc);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL b2b_retired: got %0d, expected %0d", retired, exp_ret);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b1; run = 1'b0; cond = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; op = '0;
    exp_ret = 32'd0;
    test_reset();
    test_alu_jump();
    test_load_store();
    test_branch();
    test_timeout();
    test_run_gate();
    test_halt_error();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
